// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants for the gate truth-table sweeper: FSM encoding, vector sizing, gate tables.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package testlogic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    // Expected truth tables, bit i = F for {a,b,c} = i
    localparam logic [7:0] TT_AND3 = 8'h80;
    localparam logic [7:0] TT_OR3  = 8'hFE;
    localparam logic [7:0] TT_MAJ3 = 8'hE8;
    localparam logic [7:0] TT_XOR3 = 8'h96;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and the 3-input gate under test.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request, f is a combinational reply.
// Ports: master = sweeper (drives a/b/c and status), slave = environment (drives start and f).
interface truth_table_sweeper_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       f;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] tt;
    logic [7:0] mismatch;

    modport master (
        input  start, f,
        output a, b, c, busy, done, pass, tt, mismatch
    );

    modport slave (
        output start, f,
        input  a, b, c, busy, done, pass, tt, mismatch
    );
endinterface

// File: rtl/truth_table_sweeper_hold_timer.sv
// Counts the clocks a vector has been held; flags the final hold cycle.
// Latency: last is combinational from the registered count.
// Backpressure: none; clear has priority over enable, count saturates at HOLD_CYCLES-1.
// Ports: clk, rst (sync, active-high), clear, enable in; last out.
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c} through 000..111, captures f per vector into tt, compares against EXP_TABLE.
// Latency: start accepted at edge N -> vectors from N+1, CHECK at N+1+8H, done/pass from N+2+8H.
// Backpressure: start ignored while busy; start held in DONE restarts immediately.
// Ports: clk, rst (sync, active-high), bus (master modport: start/f in, a/b/c/busy/done/pass/tt/mismatch out).
module truth_table_sweeper
    import testlogic_pkg::*;
#(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [7:0] EXP_TABLE   = 8'hE8
) (
    input  logic                         clk,
    input  logic                         rst,
    truth_table_sweeper_if.master        bus
);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] abc_q, abc_d;
    logic [7:0]       tt_q, tt_d;
    logic [7:0]       mismatch_q, mismatch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             hold_last;
    logic             in_drive;

    assign in_drive = (state_q == ST_DRIVE);

    // Outside DRIVE the timer sits at zero; each completed hold restarts it.
    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_drive || hold_last),
        .enable (in_drive),
        .last   (hold_last)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        abc_d      = abc_q;
        tt_d       = tt_q;
        mismatch_d = mismatch_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = '0;
                    abc_d      = '0;
                    tt_d       = '0;
                    mismatch_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (hold_last) begin
                    tt_d[vec_q] = bus.f;
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_CHECK;
                        abc_d   = '0;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                        // a/b/c move with vec so the gate sees the new vector on the same edge
                        abc_d = vec_q + VEC_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                state_d    = ST_DONE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                mismatch_d = tt_q ^ EXP_TABLE;
                // An unknown bit in tt makes the equality unknown, which takes the else path: pass stays 0
                pass_d     = 1'b0;
                if (tt_q == EXP_TABLE) begin
                    pass_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            abc_q      <= '0;
            tt_q       <= '0;
            mismatch_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            abc_q      <= abc_d;
            tt_q       <= tt_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.a        = abc_q[2];
    assign bus.b        = abc_q[1];
    assign bus.c        = abc_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.tt       = tt_q;
    assign bus.mismatch = mismatch_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with H=10/EXP=E8, one with H=1/EXP=FE.
// Latency: checks busy length 8H+1 and done/pass timing from the start edge.
// Backpressure: exercises start while busy, held start in DONE, reset mid-sweep.
module tb_truth_table_sweeper;
    import testlogic_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   sel;      // 0: H=10 instance, 1: H=1 instance
    int   gsel10;   // gate on each instance: 0 AND3, 1 OR3, 2 MAJ3, 3 unknown
    int   gsel1;
    int   nb;

    truth_table_sweeper_if if10();
    truth_table_sweeper_if if1();

    truth_table_sweeper #(.HOLD_CYCLES(10), .EXP_TABLE(8'hE8)) u_h10 (
        .clk (clk),
        .rst (rst),
        .bus (if10)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXP_TABLE(8'hFE)) u_h1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    function automatic logic gate(input int g, input logic [2:0] v);
        case (g)
            0:       return &v;
            1:       return |v;
            2:       return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            default: return 1'bx;
        endcase
    endfunction

    always_comb if10.f = gate(gsel10, {if10.a, if10.b, if10.c});
    always_comb if1.f  = gate(gsel1,  {if1.a,  if1.b,  if1.c});

    // View of the instance currently under test
    logic       m_busy, m_done, m_pass;
    logic [2:0] m_abc;
    logic [7:0] m_tt, m_mm;
    always_comb begin
        m_busy = (sel == 1) ? if1.busy : if10.busy;
        m_done = (sel == 1) ? if1.done : if10.done;
        m_pass = (sel == 1) ? if1.pass : if10.pass;
        m_abc  = (sel == 1) ? {if1.a, if1.b, if1.c} : {if10.a, if10.b, if10.c};
        m_tt   = (sel == 1) ? if1.tt : if10.tt;
        m_mm   = (sel == 1) ? if1.mismatch : if10.mismatch;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        if (sel == 1) if1.start = 1'b1; else if10.start = 1'b1;
        @(negedge clk);
        if (sel == 1) if1.start = 1'b0; else if10.start = 1'b0;
    endtask

    // Called on the first negedge after the accepting edge; counts busy cycles
    // and checks each vector at the start of its hold and on its last hold cycle.
    task automatic measure(input int h, input bit mid_start, output int nbusy);
        int k = 0;
        while (m_busy === 1'b1 && k < 300) begin
            if (k < 8 * h && (k % h == 0 || k % h == h - 1))
                check($sformatf("abc_k%0d", k), 32'(m_abc), 32'(k / h));
            if (k == 8 * h)
                check("abc_in_check", 32'(m_abc), 0);
            if (mid_start && k == 3 * h + 2) if10.start = 1'b1;
            if (mid_start && k == 3 * h + 3) if10.start = 1'b0;
            @(negedge clk);
            k++;
        end
        nbusy = k;
    endtask

    task automatic wait_done();
        int k = 0;
        while (m_done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", 32'(m_done), 1);
    endtask

    task automatic check_result(input string t, input int h, input int nbusy,
                                input logic [7:0] ett, input logic epass);
        check({t, "_busy_len"}, nbusy, 8 * h + 1);
        check({t, "_done"}, 32'(m_done), 1);
        check({t, "_tt"}, 32'(m_tt), 32'(ett));
        check({t, "_pass"}, 32'(m_pass), 32'(epass));
        check({t, "_mismatch"}, 32'(m_mm), 32'(ett ^ ((h == 1) ? 8'hFE : 8'hE8)));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; sel = 0;
        gsel10 = 2; gsel1 = 1;
        rst = 1'b1;
        if10.start = 1'b0;
        if1.start  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_abc", 32'(m_abc), 0);
        check("rst_busy", 32'(m_busy), 0);
        check("rst_done", 32'(m_done), 0);
        check("rst_pass", 32'(m_pass), 0);
        check("rst_tt", 32'(m_tt), 0);
        check("rst_mismatch", 32'(m_mm), 0);

        // T1: majority gate matches E8
        pulse_start();
        measure(10, 1'b0, nb);
        check_result("t1", 10, nb, TT_MAJ3, 1'b1);

        // T6: start held in DONE -> done lasts one cycle, back-to-back sweep, tt cleared
        if10.start = 1'b1;
        @(negedge clk);
        check("t6_done_drop", 32'(m_done), 0);
        check("t6_busy", 32'(m_busy), 1);
        check("t6_tt_clear", 32'(m_tt), 0);
        measure(10, 1'b0, nb);
        check_result("t6", 10, nb, TT_MAJ3, 1'b1);
        @(negedge clk);
        check("t6_done_1cyc", 32'(m_done), 0);
        check("t6_restart", 32'(m_busy), 1);
        if10.start = 1'b0;
        wait_done();

        // T2: AND3 attached, still expecting majority
        gsel10 = 0;
        pulse_start();
        measure(10, 1'b0, nb);
        check_result("t2", 10, nb, TT_AND3, 1'b0);
        check("t2_mm_const", 32'(m_mm), 32'h68);

        // T3: start re-asserted during vector 3 has no effect
        gsel10 = 2;
        pulse_start();
        measure(10, 1'b1, nb);
        check_result("t3", 10, nb, TT_MAJ3, 1'b1);

        // T4: reset while vec=5, then a full sweep
        pulse_start();
        repeat (53) @(negedge clk);
        check("t4_vec5", 32'(m_abc), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_abc", 32'(m_abc), 0);
        check("t4_busy", 32'(m_busy), 0);
        check("t4_done", 32'(m_done), 0);
        check("t4_tt", 32'(m_tt), 0);
        // rst and start together: rst wins
        rst = 1'b1;
        if10.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if10.start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(m_busy), 0);
        pulse_start();
        measure(10, 1'b0, nb);
        check_result("t4", 10, nb, TT_MAJ3, 1'b1);

        // T5: H=1, OR3, EXP=FE
        sel = 1;
        pulse_start();
        measure(1, 1'b0, nb);
        check_result("t5", 1, nb, TT_OR3, 1'b1);

        // Unknown f keeps pass low
        gsel1 = 3;
        pulse_start();
        measure(1, 1'b0, nb);
        check("x_busy_len", nb, 9);
        check("x_pass", 32'(m_pass), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
